pipe_ir_chain: RTL and testbench
================================

// Module: pipe_ir_chain
// PURPOSE
//  Parametrised instruction-register chain for the RISC pipeline: replaces the per-stage IR/EN/CLR wiring between Dataflow and pipeline_controller.
//  Holds IR plus valid bit per stage (stage 0 = IF_ID, youngest). Computes stall back-pressure, bubble insertion, per-stage flush and retirement.
//  Sits between fetch and the controller; the controller consumes stage_ir/stage_valid and drives stall_req/flush.
// PARAMETERS
//  NUM_STAGES  5        number of IR pipeline stages (>=2)
//  IR_W        16       instruction width
//  NOP_IR      16'h0000 IR value loaded into bubbles and at reset
//  CNT_W       32       width of retire_count
// PORTS
//  CLK          in   1                  single clock, rising edge
//  RST_N        in   1                  asynchronous, active-low reset
//  in_valid     in   1                  fetch offers in_ir this cycle
//  in_ir        in   IR_W               fetched instruction
//  in_ready     out  1                  stage 0 accepts in_ir at this edge
//  stall_req    in   NUM_STAGES         bit k: stage k cannot advance
//  flush        in   NUM_STAGES         bit k: squash stage k at this edge
//  stage_ir     out  NUM_STAGES*IR_W    stage k IR at bits [k*IR_W +: IR_W]
//  stage_valid  out  NUM_STAGES         stage k holds a real instruction
//  stage_hold   out  NUM_STAGES         stage k holds this cycle (EN = ~hold)
//  retire_valid out  1                  last stage leaves the pipe this cycle
//  retire_ir    out  IR_W               IR of last stage (valid with retire_valid)
//  retire_count out  CNT_W              total retired instructions
// BEHAVIOUR
//  Reset (RST_N=0, async): all stage_valid=0, all stage_ir=NOP_IR, retire_count=0. Outputs derived from state: in_ready=1, retire_valid=0.
//  hold[N-1] = valid[N-1] & stall_req[N-1]; hold[k] = valid[k] & (stall_req[k] | hold[k+1]).
//  An invalid stage never holds: bubbles collapse under stall. stall_req on an empty stage is ignored.
//  in_ready = ~hold[0]. Combinational from state and stall_req; no dependency on in_valid.
//  Next state, priority order:
//    1. flush[k]: valid<=0, ir<=NOP_IR.
//    2. hold[k]: keep contents.
//    3. k>0 and hold[k-1]: bubble (valid<=0, ir<=NOP_IR).
//    4. Otherwise take stage k-1; stage 0 takes in_valid and in_valid ? in_ir : NOP_IR.
//  flush[0] with in_valid & in_ready: the word counts as accepted and is discarded (fetch redirect).
//  Flush overrides hold on the same stage. Upstream stages still see that stage's pre-flush hold this cycle.
//  retire_valid = valid[N-1] & ~hold[N-1] & ~flush[N-1]. Combinational, one-cycle pulse per instruction. retire_ir = stage_ir[N-1].
//  retire_count += retire_valid at each edge; wraps modulo 2^CNT_W.
//  Latency: in_ir accepted at edge t is at stage k after edge t+k, with no stalls.
//  Reset mid-operation drops all in-flight instructions; no retirement is reported for them.
// CONFIGURATION
//  RISC_PIPE_PERF_EN defined: adds outputs stall_cycles [CNT_W] and bubble_count [CNT_W], reset to 0, wrap.
//    stall_cycles increments on cycles with hold[0] & in_valid.
//    bubble_count increments per edge where any stage loads a bubble via rule 3.
//  RISC_PIPE_PERF_EN undefined: those ports and counters do not exist. All other behaviour is identical.
// STRUCTURE
//  Package risc_pipe_pkg: NOP_IR encoding, stage index constants IF_ID=0, ID_RR=1, RR_EX=2, EX_MEM=3, MEM_WB=4, default IR_W.
//  Sub-module pipe_ir_stage: one stage register (valid+IR) implementing the 4-rule priority. Instantiated NUM_STAGES times via generate.
//  Hold chain and retire logic live in pipe_ir_chain.
// TESTING
//  Free flow: in_valid=1 with IR 16'h1001..16'h1008, no stalls.
//    -> 16'h1001 retires 5 cycles after acceptance; one retire per cycle; retire_count=8.
//  Stall: stall_req[2]=1 for 3 cycles while full.
//    -> stages 0-2 hold, in_ready=0, stage 3 gets 3 bubbles; retire gap of 3 cycles; no IR lost or duplicated.
//  Bubble collapse: stage 1 empty, stall_req[3]=1 for 1 cycle.
//    -> stage 0 advances into stage 1; in_ready stays 1.
//  Flush: flush=5'b00011 with 16'hBEEF at in_ir, stage 2 stalled.
//    -> stages 0,1 invalid and NOP_IR next cycle; 16'hBEEF never appears downstream; stage 2 keeps its IR.
//  Async reset: RST_N low mid-stream between edges.
//    -> stage_valid=0 and retire_count=0 immediately; after release, first retire only for new input.
//  Wrap, with CNT_W=4: retire 17 instructions.
//    -> retire_count=1. With RISC_PIPE_PERF_EN, the stall scenario gives stall_cycles=3 and bubble_count=3.

Source files
------------

// File: rtl/risc_pipe_pkg.sv
// Shared constants for the RISC pipeline IR chain: NOP encoding, default widths, stage indices.
package risc_pipe_pkg;

  localparam int          IR_W_DEF       = 16;
  localparam int          NUM_STAGES_DEF = 5;
  localparam logic [15:0] NOP_IR_DEF     = 16'h0000;

  typedef enum logic [2:0] {
    IF_ID  = 3'd0,
    ID_RR  = 3'd1,
    RR_EX  = 3'd2,
    EX_MEM = 3'd3,
    MEM_WB = 3'd4
  } stage_e;

  function automatic int ir_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/pipe_ir_stage.sv
// One IR pipeline stage register (valid + IR).
// Next-state priority: flush, then hold, then bubble, then load from upstream.
module pipe_ir_stage #(
  parameter int              IR_W   = 16,
  parameter logic [IR_W-1:0] NOP_IR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            hold,
  input  logic            bubble,
  input  logic            prev_valid,
  input  logic [IR_W-1:0] prev_ir,
  output logic            valid,
  output logic [IR_W-1:0] ir
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ir    <= NOP_IR;
    end else if (flush) begin
      valid <= 1'b0;
      ir    <= NOP_IR;
    end else if (!hold) begin
      if (bubble) begin
        valid <= 1'b0;
        ir    <= NOP_IR;
      end else begin
        valid <= prev_valid;
        ir    <= prev_ir;
      end
    end
  end

endmodule

// File: rtl/pipe_ir_chain.sv
// Parametrised IR chain: per-stage valid/IR, stall back-pressure, bubbles, flush and retirement.
// Optional performance counters (stall_cycles, bubble_count) enabled by RISC_PIPE_PERF_EN.
module pipe_ir_chain
  import risc_pipe_pkg::*;
#(
  parameter int              NUM_STAGES = NUM_STAGES_DEF,
  parameter int              IR_W       = IR_W_DEF,
  parameter logic [IR_W-1:0] NOP_IR     = IR_W'(NOP_IR_DEF),
  parameter int              CNT_W      = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [IR_W-1:0]            in_ir,
  output logic                       in_ready,
  input  logic [NUM_STAGES-1:0]      stall_req,
  input  logic [NUM_STAGES-1:0]      flush,
  output logic [NUM_STAGES*IR_W-1:0] stage_ir,
  output logic [NUM_STAGES-1:0]      stage_valid,
  output logic [NUM_STAGES-1:0]      stage_hold,
  output logic                       retire_valid,
  output logic [IR_W-1:0]            retire_ir,
  output logic [CNT_W-1:0]           retire_count
`ifdef RISC_PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]           stall_cycles,
  output logic [CNT_W-1:0]           bubble_count
`endif
);

  localparam int LAST = NUM_STAGES - 1;

  logic [NUM_STAGES-1:0] valid;
  logic [NUM_STAGES-1:0] hold;
  logic [IR_W-1:0]       ir [NUM_STAGES];

  // Only valid stages hold, so bubbles collapse under a downstream stall.
  always_comb begin
    hold       = '0;
    hold[LAST] = valid[LAST] & stall_req[LAST];
    for (int k = LAST - 1; k >= 0; k--) begin
      hold[k] = valid[k] & (stall_req[k] | hold[k+1]);
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic            prev_valid;
    logic [IR_W-1:0] prev_ir;
    logic            bubble;

    if (k == 0) begin : g_head
      assign prev_valid = in_valid;
      assign prev_ir    = in_valid ? in_ir : NOP_IR;
      assign bubble     = 1'b0;
    end else begin : g_body
      assign prev_valid = valid[k-1];
      assign prev_ir    = ir[k-1];
      assign bubble     = hold[k-1];
    end

    pipe_ir_stage #(
      .IR_W   (IR_W),
      .NOP_IR (NOP_IR)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush[k]),
      .hold       (hold[k]),
      .bubble     (bubble),
      .prev_valid (prev_valid),
      .prev_ir    (prev_ir),
      .valid      (valid[k]),
      .ir         (ir[k])
    );

    assign stage_ir[ir_lsb(k, IR_W) +: IR_W] = ir[k];
  end

  assign in_ready     = ~hold[0];
  assign stage_valid  = valid;
  assign stage_hold   = hold;
  assign retire_valid = valid[LAST] & ~hold[LAST] & ~flush[LAST];
  assign retire_ir    = ir[LAST];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_count <= '0;
    end else begin
      retire_count <= retire_count + {{(CNT_W-1){1'b0}}, retire_valid};
    end
  end

`ifdef RISC_PIPE_PERF_EN
  logic [NUM_STAGES-1:0] bubble_load;

  always_comb begin
    bubble_load = '0;
    for (int k = 1; k < NUM_STAGES; k++) begin
      bubble_load[k] = ~flush[k] & ~hold[k] & hold[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      bubble_count <= '0;
    end else begin
      stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, hold[0] & in_valid};
      bubble_count <= bubble_count + {{(CNT_W-1){1'b0}}, |bubble_load};
    end
  end
`else
  // No performance state in the default build.
`endif

endmodule

// File: tb/tb_pipe_ir_chain.sv
// Directed table-driven bench for pipe_ir_chain, plus hand sequences for reset, flush and wrap.
module tb_pipe_ir_chain;
  import risc_pipe_pkg::*;

  localparam int N  = 5;
  localparam int W  = 16;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic [W-1:0]   in_ir;
  logic           in_ready;
  logic [N-1:0]   stall_req;
  logic [N-1:0]   flush;
  logic [N*W-1:0] stage_ir;
  logic [N-1:0]   stage_valid;
  logic [N-1:0]   stage_hold;
  logic           retire_valid;
  logic [W-1:0]   retire_ir;
  logic [CW-1:0]  retire_count;
`ifdef RISC_PIPE_PERF_EN
  logic [CW-1:0]  stall_cycles;
  logic [CW-1:0]  bubble_count;
`endif

  always #5 clk = ~clk;

  pipe_ir_chain #(
    .NUM_STAGES (N),
    .IR_W       (W),
    .NOP_IR     (16'h0000),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ir        (in_ir),
    .in_ready     (in_ready),
    .stall_req    (stall_req),
    .flush        (flush),
    .stage_ir     (stage_ir),
    .stage_valid  (stage_valid),
    .stage_hold   (stage_hold),
    .retire_valid (retire_valid),
    .retire_ir    (retire_ir),
    .retire_count (retire_count)
`ifdef RISC_PIPE_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .bubble_count (bubble_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic         iv;
    logic [W-1:0] ir;
    logic [N-1:0] st;
    logic [N-1:0] fl;
    logic         rdy;
    logic         rv;
    logic [W-1:0] rir;
    logic [N-1:0] vld;
    logic [N-1:0] hld;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] get_ir(input int k);
    return stage_ir[k*W +: W];
  endfunction

  task automatic add(input logic iv, input logic [W-1:0] ir, input logic [N-1:0] st,
                     input logic rdy, input logic rv, input logic [W-1:0] rir,
                     input logic [N-1:0] vld, input logic [N-1:0] hld);
    vec_t v;
    v.iv = iv; v.ir = ir; v.st = st; v.fl = '0;
    v.rdy = rdy; v.rv = rv; v.rir = rir; v.vld = vld; v.hld = hld;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_ir     = '0;
    stall_req = '0;
    flush     = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_vecs(input string tag);
    foreach (vq[i]) begin
      in_valid  = vq[i].iv;
      in_ir     = vq[i].ir;
      stall_req = vq[i].st;
      flush     = vq[i].fl;
      #1;
      check($sformatf("%s[%0d] in_ready", tag, i), 32'(in_ready), 32'(vq[i].rdy));
      check($sformatf("%s[%0d] retire_valid", tag, i), 32'(retire_valid), 32'(vq[i].rv));
      check($sformatf("%s[%0d] stage_valid", tag, i), 32'(stage_valid), 32'(vq[i].vld));
      check($sformatf("%s[%0d] stage_hold", tag, i), 32'(stage_hold), 32'(vq[i].hld));
      if (vq[i].rv)
        check($sformatf("%s[%0d] retire_ir", tag, i), 32'(retire_ir), 32'(vq[i].rir));
      tick();
    end
    vq.delete();
    idle();
  endtask

  int n_beef;

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    check("reset stage_valid", 32'(stage_valid), 32'h0);
    check("reset stage_ir", 32'(stage_ir == '0), 32'h1);
    check("reset in_ready", 32'(in_ready), 32'h1);
    check("reset retire_valid", 32'(retire_valid), 32'h0);
    check("reset retire_count", 32'(retire_count), 32'h0);
`ifdef RISC_PIPE_PERF_EN
    check("reset stall_cycles", 32'(stall_cycles), 32'h0);
    check("reset bubble_count", 32'(bubble_count), 32'h0);
`endif
    rst_n = 1'b1;

    // Free flow: 1001..1008, no stalls
    add(1, 16'h1001, 5'b00000, 1, 0, 16'h0000, 5'b00000, 5'b00000);
    add(1, 16'h1002, 5'b00000, 1, 0, 16'h0000, 5'b00001, 5'b00000);
    add(1, 16'h1003, 5'b00000, 1, 0, 16'h0000, 5'b00011, 5'b00000);
    add(1, 16'h1004, 5'b00000, 1, 0, 16'h0000, 5'b00111, 5'b00000);
    add(1, 16'h1005, 5'b00000, 1, 0, 16'h0000, 5'b01111, 5'b00000);
    add(1, 16'h1006, 5'b00000, 1, 1, 16'h1001, 5'b11111, 5'b00000);
    add(1, 16'h1007, 5'b00000, 1, 1, 16'h1002, 5'b11111, 5'b00000);
    add(1, 16'h1008, 5'b00000, 1, 1, 16'h1003, 5'b11111, 5'b00000);
    add(0, 16'h0000, 5'b00000, 1, 1, 16'h1004, 5'b11111, 5'b00000);
    add(0, 16'h0000, 5'b00000, 1, 1, 16'h1005, 5'b11110, 5'b00000);
    add(0, 16'h0000, 5'b00000, 1, 1, 16'h1006, 5'b11100, 5'b00000);
    add(0, 16'h0000, 5'b00000, 1, 1, 16'h1007, 5'b11000, 5'b00000);
    add(0, 16'h0000, 5'b00000, 1, 1, 16'h1008, 5'b10000, 5'b00000);
    add(0, 16'h0000, 5'b00000, 1, 0, 16'h0000, 5'b00000, 5'b00000);
    run_vecs("flow");
    check("flow retire_count", 32'(retire_count), 32'd8);

    // Stall stage 2 for three cycles while the pipe is full
    do_reset();
    add(1, 16'h2001, 5'b00000, 1, 0, 16'h0000, 5'b00000, 5'b00000);
    add(1, 16'h2002, 5'b00000, 1, 0, 16'h0000, 5'b00001, 5'b00000);
    add(1, 16'h2003, 5'b00000, 1, 0, 16'h0000, 5'b00011, 5'b00000);
    add(1, 16'h2004, 5'b00000, 1, 0, 16'h0000, 5'b00111, 5'b00000);
    add(1, 16'h2005, 5'b00000, 1, 0, 16'h0000, 5'b01111, 5'b00000);
    add(1, 16'h2006, 5'b00100, 0, 1, 16'h2001, 5'b11111, 5'b00111);
    add(1, 16'h2006, 5'b00100, 0, 1, 16'h2002, 5'b10111, 5'b00111);
    add(1, 16'h2006, 5'b00100, 0, 0, 16'h0000, 5'b00111, 5'b00111);
    add(1, 16'h2006, 5'b00000, 1, 0, 16'h0000, 5'b00111, 5'b00000);
    add(1, 16'h2007, 5'b00000, 1, 0, 16'h0000, 5'b01111, 5'b00000);
    add(0, 16'h0000, 5'b00000, 1, 1, 16'h2003, 5'b11111, 5'b00000);
    add(0, 16'h0000, 5'b00000, 1, 1, 16'h2004, 5'b11110, 5'b00000);
    add(0, 16'h0000, 5'b00000, 1, 1, 16'h2005, 5'b11100, 5'b00000);
    add(0, 16'h0000, 5'b00000, 1, 1, 16'h2006, 5'b11000, 5'b00000);
    add(0, 16'h0000, 5'b00000, 1, 1, 16'h2007, 5'b10000, 5'b00000);
    add(0, 16'h0000, 5'b00000, 1, 0, 16'h0000, 5'b00000, 5'b00000);
    run_vecs("stall");
    check("stall retire_count", 32'(retire_count), 32'd7);
`ifdef RISC_PIPE_PERF_EN
    check("stall stall_cycles", 32'(stall_cycles), 32'd3);
    check("stall bubble_count", 32'(bubble_count), 32'd3);
`endif

    // Async reset between edges, with instructions in flight and a non-zero count
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_ir    = 16'h5001 + 16'(i);
      tick();
    end
    #3;
    rst_n = 1'b0;
    #1;
    check("async stage_valid", 32'(stage_valid), 32'h0);
    check("async retire_count", 32'(retire_count), 32'h0);
    check("async in_ready", 32'(in_ready), 32'h1);
    check("async retire_valid", 32'(retire_valid), 32'h0);
    idle();
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("async no stale retire", 32'(retire_count), 32'h0);
    in_valid = 1'b1;
    in_ir    = 16'h4001;
    tick();
    idle();
    repeat (4) tick();
    check("async new retire_valid", 32'(retire_valid), 32'h1);
    check("async new retire_ir", 32'(retire_ir), 32'h4001);
    tick();
    check("async new retire_count", 32'(retire_count), 32'h1);

    // Bubble collapse: stage 1 empty while stage 3 stalls
    do_reset();
    add(1, 16'h6001, 5'b00000, 1, 0, 16'h0000, 5'b00000, 5'b00000);
    add(1, 16'h6002, 5'b00000, 1, 0, 16'h0000, 5'b00001, 5'b00000);
    add(0, 16'h0000, 5'b00000, 1, 0, 16'h0000, 5'b00011, 5'b00000);
    add(1, 16'h6003, 5'b00000, 1, 0, 16'h0000, 5'b00110, 5'b00000);
    add(1, 16'h6004, 5'b01000, 1, 0, 16'h0000, 5'b01101, 5'b01100);
    add(0, 16'h0000, 5'b00000, 1, 0, 16'h0000, 5'b01111, 5'b00000);
    add(0, 16'h0000, 5'b00000, 1, 1, 16'h6001, 5'b11110, 5'b00000);
    add(0, 16'h0000, 5'b00000, 1, 1, 16'h6002, 5'b11100, 5'b00000);
    add(0, 16'h0000, 5'b00000, 1, 1, 16'h6003, 5'b11000, 5'b00000);
    add(0, 16'h0000, 5'b00000, 1, 1, 16'h6004, 5'b10000, 5'b00000);
    run_vecs("collapse");

    // Flush stages 0,1 while stage 2 stalls, then a fetch-redirect flush of stage 0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_ir    = 16'h3001 + 16'(i);
      tick();
    end
    stall_req = 5'b00100;
    flush     = 5'b00011;
    in_valid  = 1'b1;
    in_ir     = 16'hBEEF;
    #1;
    check("flush in_ready", 32'(in_ready), 32'h0);
    check("flush retire_ir", 32'(retire_ir), 32'h3001);
    tick();
    check("flush stage_valid", 32'(stage_valid), 32'b10100);
    check("flush stage0 ir", 32'(get_ir(0)), 32'h0000);
    check("flush stage1 ir", 32'(get_ir(1)), 32'h0000);
    check("flush stage2 ir", 32'(get_ir(2)), 32'h3003);
    stall_req = '0;
    flush     = 5'b00001;
    in_valid  = 1'b1;
    in_ir     = 16'hBEEF;
    #1;
    check("redirect in_ready", 32'(in_ready), 32'h1);
    tick();
    check("redirect stage0 valid", 32'(stage_valid[0]), 32'h0);
    check("redirect stage0 ir", 32'(get_ir(0)), 32'h0000);
    idle();
    n_beef = 0;
    for (int c = 0; c < 6; c++) begin
      for (int k = 0; k < N; k++)
        if (get_ir(k) == 16'hBEEF) n_beef++;
      if (retire_valid && retire_ir == 16'hBEEF) n_beef++;
      tick();
    end
    check("flush no BEEF downstream", 32'(n_beef), 32'h0);
    check("flush retire_count", 32'(retire_count), 32'd3);

    // retire_count wraps at 2^CNT_W
    do_reset();
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_ir    = 16'h7000 + 16'(i);
      tick();
    end
    idle();
    repeat (6) tick();
    check("wrap retire_count", 32'(retire_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
